// File: rtl/banked_ecc_ram.sv
// Banked single-port RAM with Hamming SECDED and independent write/read latencies.
// Define BANKED_ECC_RAM_ECC_EN for SECDED; otherwise words are stored raw and o_sec/o_ded/o_sec_cnt read 0.
module banked_ecc_ram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_DEPTH = 16,
    parameter int NUM_BANKS     = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int READ_LATENCY  = 2,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                                         i_clka,
    input  logic                                         i_rst,
    input  logic                                         i_en,
    input  logic                                         i_we,
    input  logic [$clog2(NUM_BANKS*ADDRESS_DEPTH)-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]                        i_din,
    input  logic [1:0]                                   i_err_inj,
    output logic [DATA_WIDTH-1:0]                        o_dout,
    output logic                                         o_valid,
    output logic                                         o_sec,
    output logic                                         o_ded,
    output logic [CNT_WIDTH-1:0]                         o_sec_cnt
);
    localparam int ADDR_W = $clog2(NUM_BANKS*ADDRESS_DEPTH);
    localparam int WORDS  = NUM_BANKS*ADDRESS_DEPTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sec;
        logic                  ded;
    } rd_t;

`ifdef BANKED_ECC_RAM_ECC_EN
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    localparam int P  = calc_p(DATA_WIDTH);
    localparam int CW = DATA_WIDTH + P + 1;

    // Bit index == Hamming position; position 0 holds the overall parity.
    function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [CW-1:0] cw;
        logic [P-1:0]  s;
        int            j;
        cw = '0;
        s  = '0;
        j  = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[j];
                if (d[j]) s = s ^ P'(i);
                j++;
            end
        end
        for (int k = 0; k < P; k++) cw[1 << k] = s[k];
        cw[0] = ^cw[CW-1:1];
        return cw;
    endfunction

    function automatic rd_t decode(input logic [CW-1:0] cw_in);
        logic [CW-1:0] cw;
        logic [P-1:0]  syn;
        logic          q;
        rd_t           r;
        int            j;
        cw  = cw_in;
        syn = '0;
        for (int i = 1; i < CW; i++) if (cw[i]) syn = syn ^ P'(i);
        q     = ^cw;
        r.sec = q;
        r.ded = !q && (syn != '0);
        for (int i = 0; i < CW; i++) if (q && (P'(i) == syn)) cw[i] = ~cw[i];
        r.data = '0;
        j      = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                r.data[j] = cw[i];
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] inj_mask(input logic [1:0] inj);
        logic [CW-1:0] m;
        m = '0;
        case (inj)
            2'b01:   m[0]   = 1'b1;
            2'b10:   m[1:0] = 2'b11;
            2'b11:   m[3]   = 1'b1;
            default: m      = '0;
        endcase
        return m;
    endfunction
`else
    localparam int CW = DATA_WIDTH;

    function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        return d;
    endfunction

    function automatic rd_t decode(input logic [CW-1:0] cw_in);
        rd_t r;
        r.data = cw_in;
        r.sec  = 1'b0;
        r.ded  = 1'b0;
        return r;
    endfunction

    function automatic logic [CW-1:0] inj_mask(input logic [1:0] inj);
        logic [CW-1:0] m;
        m = '0;
        case (inj)
            2'b01, 2'b11: m[0]   = 1'b1;
            2'b10:        m[1:0] = 2'b11;
            default:      m      = '0;
        endcase
        return m;
    endfunction
`endif

    // Flat array: upper address bits pick the bank, so each bank is a contiguous slice.
    logic [CW-1:0]              mem [WORDS];
    logic [WRITE_LATENCY-1:0]   w_v;
    logic [ADDR_W-1:0]          w_addr [WRITE_LATENCY];
    logic [CW-1:0]              w_cw   [WRITE_LATENCY];
    logic                       rq_v;
    logic [ADDR_W-1:0]          rq_addr;
    rd_t                        dec;
    logic [READ_LATENCY-1:0]    r_v;
    rd_t                        r_d [READ_LATENCY];
    logic                       last_in_v;
    rd_t                        last_in;
    logic [CNT_WIDTH-1:0]       sec_cnt;

    always_ff @(posedge i_clka) begin
        if (i_rst) begin
            w_v <= '0;
        end else begin
            w_v[0] <= i_en & i_we;
            for (int i = 1; i < WRITE_LATENCY; i++) w_v[i] <= w_v[i-1];
        end
        w_addr[0] <= i_addr;
        w_cw[0]   <= encode(i_din) ^ inj_mask(i_err_inj);
        for (int i = 1; i < WRITE_LATENCY; i++) begin
            w_addr[i] <= w_addr[i-1];
            w_cw[i]   <= w_cw[i-1];
        end
    end

    // Non-blocking commit makes a same-edge read see the old word.
    always_ff @(posedge i_clka) begin
        if (!i_rst && w_v[WRITE_LATENCY-1])
            mem[w_addr[WRITE_LATENCY-1]] <= w_cw[WRITE_LATENCY-1];
    end

    always_ff @(posedge i_clka) begin
        if (i_rst) rq_v <= 1'b0;
        else       rq_v <= i_en & ~i_we;
        rq_addr <= i_addr;
    end

    assign dec = decode(mem[rq_addr]);

    generate
        if (READ_LATENCY == 1) begin : g_rl1
            assign last_in_v = rq_v;
            assign last_in   = dec;
        end else begin : g_rln
            assign last_in_v = r_v[READ_LATENCY-2];
            assign last_in   = r_d[READ_LATENCY-2];
        end
    endgenerate

    // Last stage is the output register and holds when nothing new arrives.
    always_ff @(posedge i_clka) begin
        if (READ_LATENCY > 1) r_d[0] <= dec;
        for (int i = 1; i < READ_LATENCY - 1; i++) r_d[i] <= r_d[i-1];
        if (i_rst) begin
            r_v                 <= '0;
            r_d[READ_LATENCY-1] <= '0;
        end else begin
            r_v[0] <= rq_v;
            for (int i = 1; i < READ_LATENCY; i++) r_v[i] <= r_v[i-1];
            if (last_in_v) r_d[READ_LATENCY-1] <= last_in;
        end
    end

    always_ff @(posedge i_clka) begin
        if (i_rst)
            sec_cnt <= '0;
        else if (last_in_v && last_in.sec && (sec_cnt != '1))
            sec_cnt <= sec_cnt + CNT_WIDTH'(1);
    end

    assign o_valid   = r_v[READ_LATENCY-1];
    assign o_dout    = r_d[READ_LATENCY-1].data;
    assign o_sec     = r_d[READ_LATENCY-1].sec;
    assign o_ded     = r_d[READ_LATENCY-1].ded;
    assign o_sec_cnt = sec_cnt;
endmodule

// File: tb/tb_banked_ecc_ram.sv
// Directed bench for banked_ecc_ram: vector table plus pipelining, collision, reset and saturation sequences.
module tb_banked_ecc_ram;
`ifdef BANKED_ECC_RAM_ECC_EN
    localparam bit ECC = 1'b1;
`else
    localparam bit ECC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_rst, i_en, i_we;
    logic [5:0] i_addr;
    logic [7:0] i_din;
    logic [1:0] i_err_inj;
    logic [7:0] o_dout;
    logic       o_valid, o_sec, o_ded;
    logic [7:0] o_sec_cnt;

    logic       en2, we2;
    logic [5:0] addr2;
    logic [7:0] din2;
    logic [1:0] inj2;
    logic [7:0] dout2;
    logic       valid2, sec2, ded2;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    banked_ecc_ram u_dut (
        .i_clka(clk), .i_rst(i_rst), .i_en(i_en), .i_we(i_we), .i_addr(i_addr),
        .i_din(i_din), .i_err_inj(i_err_inj), .o_dout(o_dout), .o_valid(o_valid),
        .o_sec(o_sec), .o_ded(o_ded), .o_sec_cnt(o_sec_cnt)
    );

    banked_ecc_ram #(.CNT_WIDTH(2)) u_sat (
        .i_clka(clk), .i_rst(i_rst), .i_en(en2), .i_we(we2), .i_addr(addr2),
        .i_din(din2), .i_err_inj(inj2), .o_dout(dout2), .o_valid(valid2),
        .o_sec(sec2), .o_ded(ded2), .o_sec_cnt(cnt2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         we;
        logic [5:0] addr;
        logic [7:0] din;
        logic [1:0] inj;
        logic [7:0] e_dout;
        bit         e_sec;
        bit         e_ded;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_w(input logic [5:0] a, input logic [7:0] d, input logic [1:0] inj);
        vec_t v;
        v.we = 1'b1; v.addr = a; v.din = d; v.inj = inj;
        v.e_dout = '0; v.e_sec = 1'b0; v.e_ded = 1'b0; v.e_cnt = '0;
        vecs.push_back(v);
    endfunction

    function automatic void add_r(input logic [5:0] a, input logic [7:0] d, input bit s,
                                  input bit dd, input logic [7:0] c);
        vec_t v;
        v.we = 1'b0; v.addr = a; v.din = '0; v.inj = '0;
        v.e_dout = d; v.e_sec = s; v.e_ded = dd; v.e_cnt = c;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input bit we, input logic [5:0] a,
                         input logic [7:0] d, input logic [1:0] inj);
        i_en = en; i_we = we; i_addr = a; i_din = d; i_err_inj = inj;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'h00, 8'h00, 2'b00);
    endtask

    // Write and wait until it has committed (edge N+2).
    task automatic write_wait(input logic [5:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d, 2'b00);
        tick();
        idle();
        tick();
        tick();
    endtask

    initial begin
        i_rst = 1'b1;
        idle();
        en2 = 1'b0; we2 = 1'b0; addr2 = '0; din2 = '0; inj2 = '0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_dout", o_dout, 0);
        check("rst_sec", o_sec, 0);
        check("rst_ded", o_ded, 0);
        check("rst_cnt", o_sec_cnt, 0);

        add_w(6'h00, 8'hA5, 2'b00);
        add_w(6'h3F, 8'h3C, 2'b00);
        add_r(6'h00, 8'hA5, 0, 0, 0);
        add_r(6'h3F, 8'h3C, 0, 0, 0);
        add_w(6'h11, 8'h5A, 2'b11);
        add_r(6'h11, ECC ? 8'h5A : 8'h5B, ECC, 0, ECC ? 8'd1 : 8'd0);
        add_r(6'h11, ECC ? 8'h5A : 8'h5B, ECC, 0, ECC ? 8'd2 : 8'd0);
        add_w(6'h22, 8'hFF, 2'b10);
        add_r(6'h22, ECC ? 8'hFF : 8'hFC, 0, ECC, ECC ? 8'd2 : 8'd0);
        add_w(6'h07, 8'h80, 2'b01);
        add_r(6'h07, ECC ? 8'h80 : 8'h81, ECC, 0, ECC ? 8'd3 : 8'd0);
        add_w(6'h30, 8'h81, 2'b11);
        add_r(6'h30, ECC ? 8'h81 : 8'h80, ECC, 0, ECC ? 8'd4 : 8'd0);
        add_w(6'h33, 8'h01, 2'b10);
        add_r(6'h33, ECC ? 8'h01 : 8'h02, 0, ECC, ECC ? 8'd4 : 8'd0);
        add_w(6'h2A, 8'h00, 2'b00);
        add_r(6'h2A, 8'h00, 0, 0, ECC ? 8'd4 : 8'd0);

        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].we, vecs[k].addr, vecs[k].din, vecs[k].inj);
            tick();
            idle();
            tick();
            check($sformatf("v%0d_early_valid", k), o_valid, 0);
            tick();
            if (vecs[k].we) begin
                check($sformatf("v%0d_wr_valid", k), o_valid, 0);
            end else begin
                check($sformatf("v%0d_valid", k), o_valid, 1);
                check($sformatf("v%0d_dout", k), o_dout, vecs[k].e_dout);
                check($sformatf("v%0d_sec", k), o_sec, vecs[k].e_sec);
                check($sformatf("v%0d_ded", k), o_ded, vecs[k].e_ded);
                check($sformatf("v%0d_cnt", k), o_sec_cnt, vecs[k].e_cnt);
            end
        end

        // Back-to-back reads: one result per cycle, then hold.
        drive(1'b1, 1'b0, 6'h00, 8'h00, 2'b00);
        tick();
        drive(1'b1, 1'b0, 6'h3F, 8'h00, 2'b00);
        tick();
        drive(1'b1, 1'b0, 6'h2A, 8'h00, 2'b00);
        tick();
        idle();
        check("b2b_v0", o_valid, 1);
        check("b2b_d0", o_dout, 8'hA5);
        tick();
        check("b2b_v1", o_valid, 1);
        check("b2b_d1", o_dout, 8'h3C);
        tick();
        check("b2b_v2", o_valid, 1);
        check("b2b_d2", o_dout, 8'h00);
        tick();
        check("b2b_idle_valid", o_valid, 0);
        check("b2b_hold_dout", o_dout, 8'h00);

        // Commit and read access collide on the same edge: old data wins.
        write_wait(6'h05, 8'h77);
        drive(1'b1, 1'b1, 6'h05, 8'h11, 2'b00);
        tick();
        drive(1'b1, 1'b0, 6'h05, 8'h00, 2'b00);
        tick();
        drive(1'b1, 1'b0, 6'h05, 8'h00, 2'b00);
        tick();
        idle();
        check("col_pre_valid", o_valid, 0);
        tick();
        check("col_old_valid", o_valid, 1);
        check("col_old_dout", o_dout, 8'h77);
        tick();
        check("col_new_valid", o_valid, 1);
        check("col_new_dout", o_dout, 8'h11);
        tick();
        check("col_hold_valid", o_valid, 0);
        check("col_hold_dout", o_dout, 8'h11);

        // Reset while a write and a read are in flight.
        write_wait(6'h09, 8'h42);
        drive(1'b1, 1'b1, 6'h09, 8'h99, 2'b00);
        tick();
        drive(1'b1, 1'b0, 6'h09, 8'h00, 2'b00);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rstf_valid%0d", i), o_valid, 0);
            tick();
        end
        check("rstf_dout", o_dout, 0);
        check("rstf_sec", o_sec, 0);
        check("rstf_ded", o_ded, 0);
        check("rstf_cnt", o_sec_cnt, 0);
        drive(1'b1, 1'b0, 6'h09, 8'h00, 2'b00);
        tick();
        idle();
        tick();
        tick();
        check("rstf_rd_valid", o_valid, 1);
        check("rstf_rd_dout", o_dout, 8'h42);

        // Two-bit counter saturation on the second instance.
        en2 = 1'b1; we2 = 1'b1; addr2 = 6'h0C; din2 = 8'h3C; inj2 = 2'b11;
        tick();
        en2 = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            en2 = 1'b1; we2 = 1'b0; addr2 = 6'h0C; inj2 = 2'b00;
            tick();
            en2 = 1'b0;
            tick();
            tick();
            check($sformatf("sat%0d_valid", i), valid2, 1);
            check($sformatf("sat%0d_dout", i), dout2, ECC ? 8'h3C : 8'h3D);
            check($sformatf("sat%0d_sec", i), sec2, ECC);
            check($sformatf("sat%0d_cnt", i), cnt2, ECC ? ((i < 3) ? i + 1 : 3) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
